ps2_key_event_fifo: RTL
=======================

// Module: ps2_key_event_fifo
// PURPOSE
//  Second-generation PS/2 scan-code decoder: consumes the byte stream from ps2_rx and emits whole
//  key events {ext, brk, code} for make and break codes, including E0-extended keys and Pause.
//  Events are buffered in a parametrised FIFO with a valid/ready output, so the consumer no
//  longer loses keystrokes while busy. Sits between ps2_rx and the keyboard/command logic.
// PARAMETERS
//  FIFO_DEPTH   8  event FIFO depth; power of two, >= 2
//  REPORT_MAKE  1  1 = push make events; 0 = drop them
//  REPORT_BREAK 1  1 = push break events; 0 = drop them
//  TYPEMATIC_FILTER 1  1 = drop repeated makes of the key currently held
// PORTS
//  clk        in   1   system clock; all state on posedge
//  reset      in   1   asynchronous, active-low reset
//  in_valid   in   1   one-cycle strobe: in_data holds a complete received byte
//  in_data    in   8   received scan byte
//  out_valid  out  1   FIFO not empty; head event presented
//  out_ready  in   1   consumer accepts head when out_valid & out_ready
//  out_ext    out  1   head event came from an E0 (or E1 Pause) sequence
//  out_brk    out  1   head event is a release (break)
//  out_code   out  8   head event scan code
//  fifo_count out  $clog2(FIFO_DEPTH)+1  events stored
//  overflow   out  1   sticky: an event was dropped because the FIFO was full
//  clear_ovf  in   1   one-cycle pulse clears overflow
// BEHAVIOUR
//  Reset (reset=0): FSM=IDLE, FIFO empty, held-key invalid, out_valid=0, out_ext=0, out_brk=0,
//   out_code=8'h00, fifo_count=0, overflow=0. Reset mid-sequence discards partial prefixes.
//  FSM acts only on cycles with in_valid=1:
//   IDLE:  E0->EXT; F0->BRK; E1->PAUSE (skip=7); AA,FA,FE,EE,00,FF dropped; else make {0,0,b}.
//   EXT:   F0->EXT_BRK; E0/E1 restart as from IDLE; else make {1,0,b} -> IDLE.
//   BRK:   any b -> break {0,1,b} -> IDLE (F0 again stays in BRK).
//   EXT_BRK: any b -> break {1,1,b} -> IDLE (F0 stays).
//   PAUSE: decrement skip per byte; at skip 1->0 emit make {1,0,8'hE1} -> IDLE. No break for Pause.
//  Typematic: held = {ext,code} of last accepted make. If TYPEMATIC_FILTER=1 and a make equals held,
//   drop it. Break matching held invalidates held; non-matching break leaves held unchanged.
//   held updates even when REPORT_MAKE=0 or the event is dropped by overflow.
//  FIFO: first-word-fall-through; head on out_* is registered content of mem[rd_ptr].
//   Event decoded from byte sampled at edge N is written at edge N; out_valid=1 after edge N
//   (latency 1 cycle from in_valid to out_valid on an empty FIFO).
//   Pop when out_valid & out_ready. Pointers carry extra wrap bit; full = count==FIFO_DEPTH.
//   Push when full and pop same cycle: both happen, count unchanged, no overflow.
//   Push when full, no pop: event dropped, overflow<=1. clear_ovf and overflow-set same cycle:
//   overflow stays 1. Push and pop on empty: push only (no pop of invalid data).
//   out_ready ignored when out_valid=0. out_* hold value while out_valid=1 and out_ready=0.
// TESTING
//  Bytes 1C, F0 1C -> events {0,0,1C}, {0,1,1C}; fifo_count 2; pop both -> out_valid=0.
//  Bytes E0 75, E0 F0 75 -> {1,0,75}, {1,1,75}; E0 prefix alone produces no event.
//  Bytes 1C x4 (typematic) then F0 1C -> exactly {0,0,1C}, {0,1,1C}; with filter=0 -> 4 makes+1 break.
//  Pause E1 14 77 E1 F0 14 F0 77 -> single event {1,0,E1}; following 1C decodes normally.
//  out_ready=0, DEPTH=8, 9 distinct makes -> count 8, overflow=1, first 8 codes pop in order;
//   clear_ovf -> overflow=0; full push with simultaneous pop -> no overflow, count stays 8.
//  Bytes E0 F0 then reset low 1 cycle, then 1C -> only {0,0,1C}; FA/AA bytes -> no events.

Source files
------------

// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-code decoder producing {ext, brk, code} key events, buffered in a
// first-word-fall-through FIFO with valid/ready output and a sticky overflow flag.
module ps2_key_event_fifo #(
    parameter int FIFO_DEPTH       = 8,
    parameter int REPORT_MAKE      = 1,
    parameter int REPORT_BREAK     = 1,
    parameter int TYPEMATIC_FILTER = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_ext,
    output logic                          out_brk,
    output logic [7:0]                    out_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [2:0]  r_skip;
    logic [2:0]  w_nextSkip;

    logic        w_evValid;
    logic        w_evExt;
    logic        w_evBrk;
    logic [7:0]  w_evCode;
    logic        w_ignored;

    logic        r_heldValid;
    logic        r_heldExt;
    logic [7:0]  r_heldCode;
    logic        w_heldMatch;
    logic        w_isMake;
    logic        w_dropRepeat;
    logic        w_evPush;

    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [9:0]  w_head;

    assign w_ignored = (in_data == 8'hAA) || (in_data == 8'hFA) || (in_data == 8'hFE) ||
                       (in_data == 8'hEE) || (in_data == 8'h00) || (in_data == 8'hFF);

    // An E0/E1 arriving after an E0 restarts the prefix exactly as if seen in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextSkip  = r_skip;
        w_evValid   = 1'b0;
        w_evExt     = 1'b0;
        w_evBrk     = 1'b0;
        w_evCode    = in_data;
        if (in_valid) begin
            case (r_state)
                S_IDLE, S_EXT: begin
                    if (in_data == 8'hE0) begin
                        w_nextState = S_EXT;
                    end else if (in_data == 8'hE1) begin
                        w_nextState = S_PAUSE;
                        w_nextSkip  = 3'd7;
                    end else if (in_data == 8'hF0) begin
                        w_nextState = (r_state == S_EXT) ? S_EXT_BRK : S_BRK;
                    end else if (r_state == S_IDLE && w_ignored) begin
                        w_nextState = S_IDLE;
                    end else begin
                        w_evValid   = 1'b1;
                        w_evExt     = (r_state == S_EXT);
                        w_nextState = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    if (in_data != 8'hF0) begin
                        w_evValid   = 1'b1;
                        w_evBrk     = 1'b1;
                        w_evExt     = (r_state == S_EXT_BRK);
                        w_nextState = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    w_nextSkip = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_evValid   = 1'b1;
                        w_evExt     = 1'b1;
                        w_evCode    = 8'hE1;
                        w_nextState = S_IDLE;
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    assign w_isMake     = w_evValid && !w_evBrk;
    assign w_heldMatch  = r_heldValid && (r_heldExt == w_evExt) && (r_heldCode == w_evCode);
    assign w_dropRepeat = (TYPEMATIC_FILTER != 0) && w_isMake && w_heldMatch;
    assign w_evPush     = w_evValid && !w_dropRepeat &&
                          (w_isMake ? (REPORT_MAKE != 0) : (REPORT_BREAK != 0));

    assign w_count = r_wrPtr - r_rdPtr;
    assign w_full  = (w_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop   = out_valid && out_ready;
    assign w_push  = w_evPush && (!w_full || w_pop);
    assign w_drop  = w_evPush && w_full && !w_pop;
    assign w_head  = r_mem[r_rdPtr[AW-1:0]];

    assign out_valid  = (w_count != '0);
    assign out_ext    = w_head[9];
    assign out_brk    = w_head[8];
    assign out_code   = w_head[7:0];
    assign fifo_count = w_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_nextState;
            r_skip  <= w_nextSkip;
        end
    end

    // Held-key tracking follows decoded events regardless of reporting or FIFO space.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_heldValid <= 1'b0;
            r_heldExt   <= 1'b0;
            r_heldCode  <= 8'h00;
        end else if (w_isMake) begin
            r_heldValid <= 1'b1;
            r_heldExt   <= w_evExt;
            r_heldCode  <= w_evCode;
        end else if (w_evValid && w_heldMatch) begin
            r_heldValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 10'h000;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr[AW-1:0]] <= {w_evExt, w_evBrk, w_evCode};
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
